mem_rr_arbiter8: RTL and testbench
==================================

// Module: mem_rr_arbiter8
//
// PURPOSE
//   Round-robin arbiter sharing one memory port among up to 8 requesters.
//   Drives the 3-bit select of the mux8 that routes the granted requester's
//   address/wdata onto the shared port, plus mem_read/mem_write.
//   Holds the grant until mem_resp, then returns a one-cycle resp to the winner.
//   Sits between the cache/requester blocks and the shared memory.
//
// PARAMETERS
//   PTR_INIT  3'd0  first index checked after reset (round-robin start point)
//
// PORTS
//   clk        in   1  clock; all state updates on posedge
//   rst        in   1  synchronous reset, active-high
//   req_read   in   8  per-requester read request; bit i = requester i
//   req_write  in   8  per-requester write request; bit i = requester i
//   mem_resp   in   1  shared memory done (one cycle, only while busy)
//   sel        out  3  mux8 select = granted index; held while busy
//   grant      out  8  one-hot grant, bit sel, high only in BUSY
//   mem_read   out  1  shared port read strobe
//   mem_write  out  1  shared port write strobe
//   resp       out  8  one-hot completion pulse to the granted requester
//   busy       out  1  high in BUSY and RELEASE
//
// BEHAVIOUR
//   - req[i] = req_read[i] | req_write[i]. If both bits set, the op is a read.
//   - State machine (registered): IDLE -> BUSY -> RELEASE -> IDLE.
//   - IDLE: if req != 0, choose the first i with req[i] set, scanning
//     ptr, ptr+1, ... ptr+7 mod 8 (wrap 7 -> 0).
//     Next cycle: sel <= i, op <= read?1:0 (latched), state <= BUSY.
//     With no request, stay in IDLE and hold sel.
//   - BUSY outputs:
//     - grant = 1 << sel.
//     - mem_read = op_is_read; mem_write = ~op_is_read.
//     - The op is latched at grant. Changes to req_* during BUSY are ignored.
//     - A requester dropping its request mid-BUSY does NOT abort; BUSY waits for mem_resp.
//   - BUSY with mem_resp=1:
//     - resp = 1 << sel, combinational, same cycle.
//     - ptr <= sel+1 (mod 8); state <= RELEASE.
//   - RELEASE: one bubble cycle; grant/mem_read/mem_write/resp all 0.
//     Requester drops its request here. Next state is IDLE, unconditionally.
//   - Latency:
//     - req high in cycle N (IDLE) -> mem_read/mem_write high in N+1.
//     - resp in cycle M -> earliest next strobe M+3 (RELEASE M+1, IDLE arb M+2).
//   - Fairness: a requester waits at most 7 other transactions.
//   - mem_resp in IDLE or RELEASE: ignored; no resp, no state change.
//   - In IDLE/RELEASE: mem_read=mem_write=0, grant=0, resp=0; sel holds last value.
//   - Reset (any state, incl. mid-BUSY):
//     - state=IDLE, ptr=PTR_INIT, sel=0, op=read.
//     - All outputs 0 the following cycle. The in-flight transaction is abandoned.
//     - A later stale mem_resp is ignored (IDLE rule).
//   - Exactly one or zero bits of grant and resp are ever set.
//
// TESTING
//   1 Reset: rst=1 two cycles, random req -> sel=0, grant=0, resp=0, busy=0, strobes 0.
//   2 Single read: req_read=8'h04 at N -> N+1 sel=2, grant=8'h04, mem_read=1;
//     mem_resp at N+3 -> resp=8'h04 at N+3; busy=0 at N+5.
//   3 Round-robin wrap: PTR_INIT=0, req_write=8'h81 held -> grant order 0,7,0,7;
//     mem_write=1 in each BUSY.
//   4 Read+write same bit: req_read=req_write=8'h10 -> sel=4, mem_read=1, mem_write=0.
//   5 Stale/ignored events: mem_resp pulsed in IDLE -> resp=0, state IDLE.
//     Requester 3 drops req mid-BUSY -> grant holds until mem_resp, resp=8'h08.
//   6 Reset mid-BUSY (sel=5): rst=1 -> next cycle grant=0, sel=0.
//     mem_resp one cycle later -> resp=0; req=8'h20 then grants 5 from ptr 0.

Source files
------------

// File: rtl/mem_rr_arbiter8.sv
// Round-robin arbiter sharing one memory port among eight requesters.
// It holds the grant until mem_resp, then runs a one-cycle release bubble.
module mem_rr_arbiter8 #(
  parameter logic [2:0] PTR_INIT = 3'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req_read,
  input  logic [7:0] req_write,
  input  logic       mem_resp,
  output logic [2:0] sel,
  output logic [7:0] grant,
  output logic       mem_read,
  output logic       mem_write,
  output logic [7:0] resp,
  output logic       busy
);

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic               op_rd_q, op_rd_d;

  logic [N_REQ-1:0]   req;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   idx;
  logic               found;

  assign req = req_read | req_write;

  // Find the first pending request at or after ptr, wrapping 7 -> 0.
  always_comb begin
    win   = ptr_q;
    found = 1'b0;
    idx   = ptr_q;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = ptr_q + IDX_W'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= PTR_INIT;
      sel_q   <= '0;
      op_rd_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      op_rd_q <= op_rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    op_rd_d = op_rd_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = win;
          op_rd_d = req_read[win];
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mem_resp) begin
          ptr_d   = sel_q + IDX_W'(1);
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Port strobes decode from registered state; resp follows mem_resp in the same cycle.
  always_comb begin
    grant     = '0;
    resp      = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (state_q == BUSY) begin
      grant     = N_REQ'(1) << sel_q;
      mem_read  = op_rd_q;
      mem_write = ~op_rd_q;
      if (mem_resp) resp = N_REQ'(1) << sel_q;
    end
  end

  assign sel  = sel_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mem_rr_arbiter8.sv
// Scoreboard bench for mem_rr_arbiter8: stimulus queues expected grants and
// responses, and a monitor compares them as the DUT presents them.
module tb_mem_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_read, req_write;
  logic       mem_resp;
  logic [2:0] sel;
  logic [7:0] grant, resp;
  logic       mem_read, mem_write, busy;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] grant;
    logic       rd;
    logic       wr;
  } exp_t;

  exp_t       exp_grant_q[$];
  logic [7:0] exp_resp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  bit         done  = 1'b0;

  mem_rr_arbiter8 #(.PTR_INIT(3'd0)) dut (
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
    .mem_resp(mem_resp), .sel(sel), .grant(grant), .mem_read(mem_read),
    .mem_write(mem_write), .resp(resp), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Wait for the grant, hold it `hold` cycles, then return mem_resp; ends in RELEASE.
  task automatic serve(input logic [2:0] s, input logic rd, input int hold, input bit drop);
    exp_t e;
    int   n;
    e.sel = s; e.grant = 8'(1) << s; e.rd = rd; e.wr = ~rd;
    exp_grant_q.push_back(e);
    n = 0;
    tick();
    while (grant == 8'h00 && n < 10) begin
      tick();
      n++;
    end
    if (grant == 8'h00) begin
      n_cmp++;
      n_err++;
      $display("FAIL grant_timeout: no grant seen, expected sel %0d", s);
      return;
    end
    if (drop) begin
      req_read  = 8'h00;
      req_write = 8'h00;
    end
    repeat (hold) tick();
    check("grant_held", grant, e.grant);
    mem_resp = 1'b1;
    exp_resp_q.push_back(e.grant);
    tick();
    mem_resp = 1'b0;
  endtask

  // Monitor: new grants and every resp pulse are matched against the queues.
  initial begin
    exp_t       cur;
    logic [7:0] prev_grant;
    logic [7:0] r;
    prev_grant = 8'h00;
    cur.sel = '0; cur.grant = '0; cur.rd = 1'b0; cur.wr = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (grant != 8'h00 && prev_grant == 8'h00) begin
        if (exp_grant_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_grant: got %h expected none", grant);
        end else begin
          cur = exp_grant_q.pop_front();
          check("grant", grant, cur.grant);
          check("sel", 8'(sel), 8'(cur.sel));
          check("mem_read", 8'(mem_read), 8'(cur.rd));
          check("mem_write", 8'(mem_write), 8'(cur.wr));
          check("busy_in_busy", 8'(busy), 8'h01);
        end
      end
      if (resp != 8'h00) begin
        if (exp_resp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_resp: got %h expected 00", resp);
        end else begin
          r = exp_resp_q.pop_front();
          check("resp", resp, r);
        end
      end
      prev_grant = grant;
    end
  end

  initial begin
    rst = 1'b1; req_read = '0; req_write = '0; mem_resp = 1'b0;

    // Reset with random requests present.
    req_read  = 8'($urandom);
    req_write = 8'($urandom);
    tick(); tick();
    check("rst_sel", 8'(sel), 8'h00);
    check("rst_grant", grant, 8'h00);
    check("rst_resp", resp, 8'h00);
    check("rst_busy", 8'(busy), 8'h00);
    check("rst_strobes", 8'({mem_read, mem_write}), 8'h00);
    req_read = '0; req_write = '0;
    rst = 1'b0;
    tick();

    // Single read from requester 2; resp two cycles into BUSY.
    req_read = 8'h04;
    serve(3'd2, 1'b1, 2, 1'b0);
    req_read = 8'h00;
    check("release_busy", 8'(busy), 8'h01);
    check("release_grant", grant, 8'h00);
    tick();
    check("idle_busy", 8'(busy), 8'h00);
    check("idle_sel_hold", 8'(sel), 8'h02);

    // Round-robin wrap from ptr 0 with requesters 0 and 7 writing.
    do_reset();
    req_write = 8'h81;
    serve(3'd0, 1'b0, 1, 1'b0);
    serve(3'd7, 1'b0, 0, 1'b0);
    serve(3'd0, 1'b0, 2, 1'b0);
    serve(3'd7, 1'b0, 1, 1'b0);
    req_write = 8'h00;
    tick();

    // Read and write on the same bit resolves to a read.
    req_read = 8'h10; req_write = 8'h10;
    serve(3'd4, 1'b1, 1, 1'b0);
    req_read = 8'h00; req_write = 8'h00;
    tick();

    // Stale mem_resp in IDLE is ignored.
    mem_resp = 1'b1;
    #1;
    check("stale_resp_idle", resp, 8'h00);
    tick();
    mem_resp = 1'b0;
    check("stale_busy", 8'(busy), 8'h00);

    // Requester 3 drops its request mid-BUSY; transaction still completes.
    req_write = 8'h08;
    serve(3'd3, 1'b0, 3, 1'b1);
    tick();

    // Reset in the middle of a grant to requester 5.
    req_read = 8'h20;
    begin
      exp_t e;
      e.sel = 3'd5; e.grant = 8'h20; e.rd = 1'b1; e.wr = 1'b0;
      exp_grant_q.push_back(e);
    end
    tick();
    check("pre_rst_grant", grant, 8'h20);
    rst = 1'b1; req_read = 8'h00;
    tick();
    rst = 1'b0;
    check("midrst_grant", grant, 8'h00);
    check("midrst_sel", 8'(sel), 8'h00);
    check("midrst_busy", 8'(busy), 8'h00);
    mem_resp = 1'b1;
    #1;
    check("midrst_stale_resp", resp, 8'h00);
    tick();
    mem_resp = 1'b0;
    // ptr is back at 0, so requester 0 beats requester 5.
    req_read = 8'h21;
    serve(3'd0, 1'b1, 1, 1'b0);
    req_read = 8'h00;
    tick();
    req_read = 8'h20;
    serve(3'd5, 1'b1, 1, 1'b0);
    req_read = 8'h00;
    tick(); tick();

    check("grant_queue_empty", 8'(exp_grant_q.size()), 8'h00);
    check("resp_queue_empty", 8'(exp_resp_q.size()), 8'h00);
    done = 1'b1;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
